// File: rtl/dmac_dot_engine_if.sv
// -----------------------------------------------------------------------------
// dmac_dot_engine_if
// Purpose : Control/data bundle between a host (or pin wrapper) and the
//           dmac_dot_engine dot-product core.
// Parameters : DATA_W (operand width), DEPTH (bank entries), ACC_W (acc width)
// Signals :
//   load  host->core  write strobe (bank A/B, LEN, or clear acc+ovf)
//   run   host->core  start request
//   insn  host->core  2-bit opcode qualifying load / run
//   index host->core  bank address or LEN value
//   data  host->core  operand write data
//   out   core->host  accumulator value
//   ovf   core->host  sticky overflow flag
//   busy  core->host  high while a dot product is in flight
//   done  core->host  one-cycle completion pulse
// Modports : master (host side), slave (core side)
// -----------------------------------------------------------------------------
interface dmac_dot_engine_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int ACC_W  = 12
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              load;
    logic              run;
    logic [1:0]        insn;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
    logic [ACC_W-1:0]  out;
    logic              ovf;
    logic              busy;
    logic              done;

    modport master (
        output load, run, insn, index, data,
        input  out, ovf, busy, done
    );

    modport slave (
        input  load, run, insn, index, data,
        output out, ovf, busy, done
    );
endinterface

// File: rtl/dmac_dot_engine.sv
// -----------------------------------------------------------------------------
// dmac_dot_engine
// Purpose : Dot-product engine. Two operand banks A and B are written through
//           load commands; a run computes sum(A[i]*B[i]) for i = 0..LEN, one
//           term per clock, into an ACC_W-bit accumulator with signed or
//           unsigned arithmetic, optional clear at start and a sticky
//           overflow flag.
// Configuration macro : MAC_SAT_EN
//           defined   -> an overflowing add clamps the accumulator
//                        (unsigned: all ones; signed: max positive / min
//                        negative), ovf is still set.
//           undefined -> the accumulator wraps modulo 2^ACC_W.
// Ports :
//   clk  in   single clock, rising edge
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of dmac_dot_engine_if (load/run/insn/index/data in,
//        out/ovf/busy/done out)
// -----------------------------------------------------------------------------
module dmac_dot_engine #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    dmac_dot_engine_if.slave  bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_W-1:0] r_bank_a [DEPTH];
    logic [DATA_W-1:0] r_bank_b [DEPTH];
    logic [IDX_W-1:0]  r_len;
    logic [IDX_W-1:0]  r_ptr;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic              r_signed;

    logic                     w_last;
    logic [DATA_W-1:0]        w_op_a;
    logic [DATA_W-1:0]        w_op_b;
    logic [PROD_W-1:0]        w_prod_u;
    logic signed [PROD_W-1:0] w_ext_a_s;
    logic signed [PROD_W-1:0] w_ext_b_s;
    logic signed [PROD_W-1:0] w_prod_s;
    logic [ACC_W-1:0]         w_term;
    logic [ACC_W:0]           w_sum;
    logic                     w_carry;
    logic                     w_sovf;
    logic                     w_add_ovf;
    logic [ACC_W-1:0]         w_acc_next;

    // The run ends on the term whose index equals LEN, so ptr never wraps.
    assign w_last = (r_ptr == r_len);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first means every path drives
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.run) w_next_state = ST_RUN;
            ST_RUN:  if (w_last)  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Term product and accumulate
    // ------------------------------------------------------------------
    assign w_op_a    = r_bank_a[r_ptr];
    assign w_op_b    = r_bank_b[r_ptr];
    assign w_prod_u  = PROD_W'(w_op_a) * PROD_W'(w_op_b);
    assign w_ext_a_s = PROD_W'($signed(w_op_a));
    assign w_ext_b_s = PROD_W'($signed(w_op_b));
    assign w_prod_s  = w_ext_a_s * w_ext_b_s;

    // Zero-extend the product in unsigned mode, sign-extend it in signed mode.
    always_comb begin
        w_term = ACC_W'(w_prod_u);
        if (r_signed) begin
            w_term = ACC_W'(w_prod_s);
        end
    end

    assign w_sum   = {1'b0, r_acc} + {1'b0, w_term};
    assign w_carry = w_sum[ACC_W];
    // Signed overflow: both addends share a sign that the result does not.
    assign w_sovf  = (r_acc[ACC_W-1] == w_term[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_add_ovf = r_signed ? w_sovf : w_carry;

`ifdef MAC_SAT_EN
    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_add_ovf) begin
            if (!r_signed) begin
                w_acc_next = '1;
            end else if (r_acc[ACC_W-1]) begin
                // Two negatives overflowed: clamp to the most negative value.
                w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    // ------------------------------------------------------------------
    // Datapath registers: banks, LEN, pointer, accumulator, flags
    // ------------------------------------------------------------------
    // NOTE: the operand banks are reset along with the rest of the state
    // because software relies on A/B reading back as zero after reset;
    // this forces them into flops instead of a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank_a[i] <= '0;
                r_bank_b[i] <= '0;
            end
            r_len    <= '0;
            r_ptr    <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_signed <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // run wins over a simultaneous load; that load is dropped.
                    if (bus.run) begin
                        r_signed <= bus.insn[1];
                        r_ptr    <= '0;
                        if (bus.insn[0]) begin
                            r_acc <= '0;
                            r_ovf <= 1'b0;
                        end
                    end else if (bus.load) begin
                        unique case (bus.insn)
                            2'b00: r_bank_a[bus.index] <= bus.data;
                            2'b01: r_bank_b[bus.index] <= bus.data;
                            2'b10: r_len <= bus.index;
                            2'b11: begin
                                r_acc <= '0;
                                r_ovf <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_add_ovf;
                    if (!w_last) begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out  = r_acc;
    assign bus.ovf  = r_ovf;
    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = (r_state == ST_DONE);

endmodule
